recovery_ctrl: RTL and testbench
================================

RECOVERY_CTRL -- requirements
Module: recovery_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 5: register-file address width; NUM_REG = 2**ADDR_WIDTH entries copied per recovery.
REQ-002 Parameter NUM_CORES, default 3: number of lockstep cores monitored; CORE_W = max(1, $clog2(NUM_CORES)).
REQ-003 Parameter MAX_RETRY, default 3: consecutive failed recoveries tolerated before FAIL.
REQ-004 Parameter HALT_TIMEOUT, default 16: cycles allowed for halt acknowledge.
REQ-005 Ports, in order:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- error_i  in  NUM_CORES  per-core mismatch flag from voter.
- halted_i  in  1  all cores report halted.
- halt_o  out  1  halt request.
- shift_o  out  1  one-cycle PC/state copy strobe.
- replay_we_o  out  1  replay_addr_o is valid; copy this GPR.
- replay_addr_o  out  ADDR_WIDTH  GPR index being copied.
- resume_o  out  1  one-cycle resume strobe.
- faulty_core_o  out  CORE_W  index of the core being repaired.
- busy_o  out  1  high in any state except IDLE and FAIL.
- fail_o  out  1  sticky unrecoverable flag.
- retry_cnt_o  out  $clog2(MAX_RETRY+1)  consecutive retries.

Function
REQ-010 FSM states: IDLE, HALT_REQ, SHIFT, COPY, RESUME, FAIL; all outputs are registered (Moore).
REQ-011 IDLE: if exactly one error_i bit is set, capture its index into faulty_core_o and go to HALT_REQ next cycle.
REQ-012 IDLE: if two or more error_i bits are set in the same cycle, go to FAIL, because a majority is lost.
REQ-013 HALT_REQ: halt_o=1; a timeout counter increments each cycle.
- halted_i=1 -> SHIFT.
- Counter reaches HALT_TIMEOUT without halted_i -> FAIL.
REQ-014 SHIFT: shift_o=1 and halt_o=1 for exactly one cycle -> COPY with replay_addr_o=0.
REQ-015 COPY: replay_we_o=1 and halt_o=1; replay_addr_o increments by 1 each cycle from 0 to NUM_REG-1, with no wrap; after NUM_REG cycles -> RESUME.
REQ-016 RESUME: resume_o=1 and halt_o=0 for exactly one cycle, then go to IDLE.
REQ-017 Latency: from the first cycle halted_i is sampled high, resume_o rises exactly NUM_REG+2 cycles later.
REQ-018 Any error_i bit seen while busy sets a pending flag; it does not abort the sequence.
REQ-019 On leaving RESUME:
- Pending set -> retry_cnt_o increments, pending clears, FSM re-enters HALT_REQ with a fresh faulty_core_o capture.
- Pending clear -> retry_cnt_o clears.
REQ-020 If retry_cnt_o would exceed MAX_RETRY, go to FAIL instead of HALT_REQ.
REQ-021 FAIL: fail_o=1 and halt_o=1; all strobes are 0; the FSM stays in FAIL until rst_i.
REQ-022 replay_addr_o holds its last value outside COPY; consumers qualify it with replay_we_o.
REQ-023 Counters saturate; no arithmetic wrap occurs in any state.

Reset
REQ-030 rst_i sampled high -> IDLE next cycle; all outputs, pending flag, timeout counter and retry counter become 0.
REQ-031 Reset takes priority over every transition, including mid-COPY and FAIL; no strobe fires in the cycle after reset.

Structure
REQ-040 Package recovery_pkg holds the state enum type and the priority-encoder/popcount function used for error_i decoding.
REQ-041 Single module; no sub-module is required.
REQ-042 The FSM uses one sequential block with nonblocking assignments only.

Verification
REQ-050 Error, ADDR_WIDTH=5:
- Stimulus: error_i=3'b010 one cycle; halted_i rises 2 cycles after halt_o.
- Response: faulty_core_o=1; shift_o for one cycle; replay_we_o for 32 cycles with addresses 0..31; resume_o 34 cycles after halted_i is sampled; retry_cnt_o=0.
REQ-051 Double error: error_i=3'b011 -> FAIL next cycle; fail_o=1, halt_o=1, no shift_o.
REQ-052 Halt timeout: error_i=3'b001 with halted_i held 0 -> fail_o=1 after 16 HALT_REQ cycles.
REQ-053 Error during recovery:
- Stimulus: error_i=3'b100 pulsed during COPY.
- Response: after resume_o, the FSM re-enters HALT_REQ with faulty_core_o=2 and retry_cnt_o=1.
- Stimulus: repeat the pulse 3 more times.
- Response: fail_o=1.
REQ-054 Reset mid-COPY: assert rst_i at replay_addr_o=7 -> next cycle every output is 0, state is IDLE, and no resume_o is issued.

Source files
------------

// File: rtl/recovery_pkg.sv
// Shared types and error-vector decode helpers for the lockstep recovery controller.
package recovery_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_REQ,
    S_SHIFT,
    S_COPY,
    S_RESUME,
    S_FAIL
  } state_t;

  localparam int MAX_CORES = 32;

  function automatic int core_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int popcount(input logic [MAX_CORES-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < MAX_CORES; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Lowest set bit wins; returns 0 for an all-zero vector.
  function automatic int lowest_set(input logic [MAX_CORES-1:0] v);
    int idx;
    idx = 0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/recovery_ctrl_if.sv
// Voter/core-side signal bundle of the recovery controller.
// master = controller, slave = lockstep cores and voter.
interface recovery_ctrl_if
  import recovery_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_CORES  = 3,
  parameter int MAX_RETRY  = 3
);
  localparam int CORE_W  = core_width(NUM_CORES);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  logic [NUM_CORES-1:0]  error_i;
  logic                  halted_i;
  logic                  halt_o;
  logic                  shift_o;
  logic                  replay_we_o;
  logic [ADDR_WIDTH-1:0] replay_addr_o;
  logic                  resume_o;
  logic [CORE_W-1:0]     faulty_core_o;
  logic                  busy_o;
  logic                  fail_o;
  logic [RETRY_W-1:0]    retry_cnt_o;

  modport master (
    input  error_i, halted_i,
    output halt_o, shift_o, replay_we_o, replay_addr_o, resume_o,
           faulty_core_o, busy_o, fail_o, retry_cnt_o
  );

  modport slave (
    output error_i, halted_i,
    input  halt_o, shift_o, replay_we_o, replay_addr_o, resume_o,
           faulty_core_o, busy_o, fail_o, retry_cnt_o
  );
endinterface

// File: rtl/recovery_ctrl.sv
// Lockstep recovery sequencer: halt, state shift, GPR replay copy, resume; all outputs registered.
// resume_o follows the first sampled halted_i by NUM_REG+2 cycles; halt ack is bounded by HALT_TIMEOUT.
module recovery_ctrl
  import recovery_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int NUM_CORES    = 3,
  parameter int MAX_RETRY    = 3,
  parameter int HALT_TIMEOUT = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  recovery_ctrl_if.master bus
);

  localparam int NUM_REG = 2 ** ADDR_WIDTH;
  localparam int CORE_W  = core_width(NUM_CORES);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int TMO_W   = $clog2(HALT_TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REG - 1);
  localparam logic [RETRY_W-1:0]    RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(HALT_TIMEOUT - 1);

  state_t                state;
  logic                  halt_q, shift_q, we_q, resume_q, busy_q, fail_q;
  logic                  pending_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CORE_W-1:0]     faulty_q, pend_core_q;
  logic [RETRY_W-1:0]    retry_q;
  logic [TMO_W-1:0]      tmo_q;

  logic [MAX_CORES-1:0]  err_vec;
  int                    err_cnt;
  logic [CORE_W-1:0]     err_idx;
  logic                  err_any;

  assign err_vec = MAX_CORES'(bus.error_i);
  assign err_cnt = popcount(err_vec);
  assign err_idx = CORE_W'(lowest_set(err_vec));
  assign err_any = |bus.error_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      halt_q      <= 1'b0;
      shift_q     <= 1'b0;
      we_q        <= 1'b0;
      resume_q    <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
      pending_q   <= 1'b0;
      addr_q      <= '0;
      faulty_q    <= '0;
      pend_core_q <= '0;
      retry_q     <= '0;
      tmo_q       <= '0;
    end else begin
      shift_q  <= 1'b0;
      we_q     <= 1'b0;
      resume_q <= 1'b0;

      // Errors during a repair are remembered, not acted on, until RESUME.
      if (busy_q && err_any) begin
        pending_q   <= 1'b1;
        pend_core_q <= err_idx;
      end

      case (state)
        S_IDLE: begin
          if (err_cnt == 1) begin
            state    <= S_HALT_REQ;
            faulty_q <= err_idx;
            halt_q   <= 1'b1;
            busy_q   <= 1'b1;
            tmo_q    <= '0;
          end else if (err_cnt >= 2) begin
            state  <= S_FAIL;
            fail_q <= 1'b1;
            halt_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end

        S_HALT_REQ: begin
          if (bus.halted_i) begin
            state   <= S_SHIFT;
            shift_q <= 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            state  <= S_FAIL;
            fail_q <= 1'b1;
            halt_q <= 1'b1;
            busy_q <= 1'b0;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_SHIFT: begin
          state  <= S_COPY;
          we_q   <= 1'b1;
          addr_q <= '0;
        end

        S_COPY: begin
          if (addr_q == LAST_ADDR) begin
            state    <= S_RESUME;
            resume_q <= 1'b1;
            halt_q   <= 1'b0;
          end else begin
            we_q   <= 1'b1;
            addr_q <= addr_q + 1'b1;
          end
        end

        S_RESUME: begin
          if (pending_q || err_any) begin
            pending_q <= 1'b0;
            if (retry_q == RETRY_MAX) begin
              state  <= S_FAIL;
              fail_q <= 1'b1;
              halt_q <= 1'b1;
              busy_q <= 1'b0;
            end else begin
              state    <= S_HALT_REQ;
              retry_q  <= retry_q + 1'b1;
              faulty_q <= err_any ? err_idx : pend_core_q;
              halt_q   <= 1'b1;
              tmo_q    <= '0;
            end
          end else begin
            state   <= S_IDLE;
            retry_q <= '0;
            busy_q  <= 1'b0;
          end
        end

        S_FAIL: begin
          state <= S_FAIL;
        end

        default: begin
          state  <= S_FAIL;
          fail_q <= 1'b1;
          halt_q <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.halt_o        = halt_q;
  assign bus.shift_o       = shift_q;
  assign bus.replay_we_o   = we_q;
  assign bus.replay_addr_o = addr_q;
  assign bus.resume_o      = resume_q;
  assign bus.faulty_core_o = faulty_q;
  assign bus.busy_o        = busy_q;
  assign bus.fail_o        = fail_q;
  assign bus.retry_cnt_o   = retry_q;

endmodule

// File: tb/tb_recovery_ctrl.sv
// Self-checking bench for recovery_ctrl: directed scenarios plus randomized repair chains
// predicted by a transaction-level model (latency, copy shape, retry and fail outcomes).
module tb_recovery_ctrl;

  localparam int AW   = 5;
  localparam int NC   = 3;
  localparam int MR   = 3;
  localparam int HT   = 16;
  localparam int NREG = 2 ** AW;
  localparam int LAT  = NREG + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  recovery_ctrl_if #(.ADDR_WIDTH(AW), .NUM_CORES(NC), .MAX_RETRY(MR)) bus ();

  recovery_ctrl #(
    .ADDR_WIDTH(AW), .NUM_CORES(NC), .MAX_RETRY(MR), .HALT_TIMEOUT(HT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [14:0] outs();
    return {bus.halt_o, bus.shift_o, bus.replay_we_o, bus.replay_addr_o, bus.resume_o,
            bus.faulty_core_o, bus.busy_o, bus.fail_o, bus.retry_cnt_o};
  endfunction

  function automatic int ones(input logic [NC-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < NC; i++) if (v[i]) c++;
    return c;
  endfunction

  function automatic int low(input logic [NC-1:0] v);
    for (int i = 0; i < NC; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic do_reset();
    bus.error_i  = '0;
    bus.halted_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_error(input logic [NC-1:0] v);
    bus.error_i = v;
    tick();
    bus.error_i = '0;
  endtask

  // Acts as the cores: acks halt after dly cycles, optionally pulses an error mid-copy,
  // and reports what the controller did up to resume_o.
  task automatic drive_recovery(input int dly, input int pulse_at, input logic [NC-1:0] pval,
                                output int lat, output int n_shift, output int n_we,
                                output bit addr_ok, output bit halt_ok);
    int exp_addr;
    exp_addr = 0;
    lat = -1; n_shift = 0; n_we = 0; addr_ok = 1'b1; halt_ok = 1'b1;
    repeat (dly) tick();
    bus.halted_i = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      bus.error_i = '0;
      if (bus.shift_o === 1'b1) begin
        n_shift++;
        bus.halted_i = 1'b0;
      end
      if (bus.replay_we_o === 1'b1) begin
        if (int'(bus.replay_addr_o) != exp_addr) addr_ok = 1'b0;
        exp_addr++;
        n_we++;
        if (int'(bus.replay_addr_o) == pulse_at) bus.error_i = pval;
      end
      if (bus.resume_o === 1'b1) begin
        lat = c;
        if (bus.halt_o !== 1'b0) halt_ok = 1'b0;
        break;
      end else if (bus.halt_o !== 1'b1) begin
        halt_ok = 1'b0;
      end
    end
    bus.halted_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (outs() !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", outs());
    end
  endtask

  task automatic test_single_error();
    int lat, ns, nw;
    bit aok, hok;
    do_reset();
    start_error(3'b010);
    checks++;
    if ({bus.faulty_core_o, bus.halt_o, bus.busy_o} !== {2'd1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL single_capture got core=%0d halt=%b busy=%b expected core=1 halt=1 busy=1",
               bus.faulty_core_o, bus.halt_o, bus.busy_o);
    end
    drive_recovery(2, -1, '0, lat, ns, nw, aok, hok);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL single_latency got %0d expected %0d", lat, LAT);
    end
    checks++;
    if (ns != 1 || nw != NREG || !aok || !hok) begin
      errors++;
      $display("FAIL single_copy_shape got shift=%0d we=%0d addr_ok=%0b halt_ok=%0b expected 1 %0d 1 1",
               ns, nw, aok, hok, NREG);
    end
    tick();
    checks++;
    if ({bus.busy_o, bus.halt_o, bus.resume_o, bus.retry_cnt_o, bus.fail_o} !== 6'd0) begin
      errors++;
      $display("FAIL single_back_to_idle got busy=%b halt=%b resume=%b retry=%0d fail=%b expected all 0",
               bus.busy_o, bus.halt_o, bus.resume_o, bus.retry_cnt_o, bus.fail_o);
    end
  endtask

  task automatic test_double_error();
    bit stuck_ok;
    do_reset();
    start_error(3'b011);
    checks++;
    if ({bus.fail_o, bus.halt_o, bus.shift_o, bus.busy_o} !== 4'b1100) begin
      errors++;
      $display("FAIL double_fail got fail=%b halt=%b shift=%b busy=%b expected 1 1 0 0",
               bus.fail_o, bus.halt_o, bus.shift_o, bus.busy_o);
    end
    stuck_ok = 1'b1;
    bus.halted_i = 1'b1;
    bus.error_i  = 3'b001;
    repeat (6) begin
      tick();
      if (bus.fail_o !== 1'b1 || bus.shift_o !== 1'b0 || bus.resume_o !== 1'b0) stuck_ok = 1'b0;
    end
    checks++;
    if (!stuck_ok) begin
      errors++;
      $display("FAIL fail_sticky got left FAIL or strobed expected sticky FAIL");
    end
    do_reset();
    checks++;
    if (outs() !== 15'd0) begin
      errors++;
      $display("FAIL reset_from_fail got %h expected 0", outs());
    end
  endtask

  task automatic test_halt_timeout();
    int n;
    do_reset();
    start_error(3'b001);
    n = -1;
    for (int c = 1; c <= HT + 8; c++) begin
      tick();
      if (bus.fail_o === 1'b1) begin
        n = c;
        break;
      end
    end
    checks++;
    if (n != HT || bus.halt_o !== 1'b1) begin
      errors++;
      $display("FAIL halt_timeout got cycles=%0d halt=%b expected %0d 1", n, bus.halt_o, HT);
    end
  endtask

  task automatic test_retry_chain();
    int lat, ns, nw;
    bit aok, hok;
    do_reset();
    start_error(3'b001);
    for (int k = 0; k <= MR; k++) begin
      drive_recovery(1, 5 + k, 3'b100, lat, ns, nw, aok, hok);
      checks++;
      if (lat != LAT || nw != NREG || !aok) begin
        errors++;
        $display("FAIL retry_pass%0d got lat=%0d we=%0d addr_ok=%0b expected %0d %0d 1",
                 k, lat, nw, aok, LAT, NREG);
      end
      tick();
      checks++;
      if (k < MR) begin
        if ({bus.faulty_core_o, bus.retry_cnt_o, bus.halt_o, bus.busy_o} !== {2'd2, 2'(k + 1), 2'b11}) begin
          errors++;
          $display("FAIL retry_reenter%0d got core=%0d retry=%0d halt=%b busy=%b expected 2 %0d 1 1",
                   k, bus.faulty_core_o, bus.retry_cnt_o, bus.halt_o, bus.busy_o, k + 1);
        end
      end else if ({bus.fail_o, bus.halt_o} !== 2'b11) begin
        errors++;
        $display("FAIL retry_exhausted got fail=%b halt=%b expected 1 1", bus.fail_o, bus.halt_o);
      end
    end
  endtask

  task automatic test_reset_mid_copy();
    bit found, quiet;
    do_reset();
    start_error(3'b001);
    bus.halted_i = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (bus.shift_o === 1'b1) bus.halted_i = 1'b0;
      if (bus.replay_we_o === 1'b1 && bus.replay_addr_o === 5'd7) begin
        found = 1'b1;
        break;
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (!found || outs() !== 15'd0) begin
      errors++;
      $display("FAIL reset_mid_copy got reached=%0b outs=%h expected 1 0", found, outs());
    end
    quiet = 1'b1;
    repeat (40) begin
      tick();
      if (bus.resume_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.halt_o !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL post_reset_quiet got activity after reset expected idle");
    end
  endtask

  task automatic test_random();
    logic [NC-1:0] v, pv;
    int r, dly, pulse, n, lat, ns, nw;
    bit aok, hok, done;
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      v = NC'($urandom_range(1, 7));
      start_error(v);
      if (ones(v) >= 2) begin
        checks++;
        if ({bus.fail_o, bus.halt_o, bus.busy_o} !== 3'b110) begin
          errors++;
          $display("FAIL rnd_multi ep%0d v=%b got fail=%b halt=%b busy=%b expected 1 1 0",
                   ep, v, bus.fail_o, bus.halt_o, bus.busy_o);
        end
        continue;
      end
      checks++;
      if (bus.faulty_core_o !== 2'(low(v))) begin
        errors++;
        $display("FAIL rnd_capture ep%0d got %0d expected %0d", ep, bus.faulty_core_o, low(v));
      end
      r = 0;
      done = 1'b0;
      while (!done) begin
        dly = $urandom_range(0, HT + 1);
        if (dly >= HT) begin
          n = -1;
          for (int c = 1; c <= HT + 4; c++) begin
            tick();
            if (bus.fail_o === 1'b1) begin
              n = c;
              break;
            end
          end
          checks++;
          if (n != HT) begin
            errors++;
            $display("FAIL rnd_timeout ep%0d got %0d expected %0d", ep, n, HT);
          end
          done = 1'b1;
        end else begin
          pulse = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NREG - 1)) : -1;
          pv = NC'(1) << $urandom_range(0, NC - 1);
          drive_recovery(dly, pulse, pv, lat, ns, nw, aok, hok);
          checks++;
          if (lat != LAT || ns != 1 || nw != NREG || !aok || !hok) begin
            errors++;
            $display("FAIL rnd_repair ep%0d got lat=%0d shift=%0d we=%0d addr_ok=%0b halt_ok=%0b expected %0d 1 %0d 1 1",
                     ep, lat, ns, nw, aok, hok, LAT, NREG);
          end
          tick();
          checks++;
          if (pulse < 0) begin
            done = 1'b1;
            if ({bus.busy_o, bus.halt_o, bus.retry_cnt_o, bus.fail_o} !== 5'd0) begin
              errors++;
              $display("FAIL rnd_idle ep%0d got busy=%b halt=%b retry=%0d fail=%b expected 0",
                       ep, bus.busy_o, bus.halt_o, bus.retry_cnt_o, bus.fail_o);
            end
          end else if (r == MR) begin
            done = 1'b1;
            if ({bus.fail_o, bus.halt_o, bus.busy_o} !== 3'b110) begin
              errors++;
              $display("FAIL rnd_exhaust ep%0d got fail=%b halt=%b busy=%b expected 1 1 0",
                       ep, bus.fail_o, bus.halt_o, bus.busy_o);
            end
          end else begin
            r++;
            if ({bus.faulty_core_o, bus.retry_cnt_o, bus.halt_o, bus.busy_o} !== {2'(low(pv)), 2'(r), 2'b11}) begin
              errors++;
              $display("FAIL rnd_retry ep%0d got core=%0d retry=%0d halt=%b busy=%b expected %0d %0d 1 1",
                       ep, bus.faulty_core_o, bus.retry_cnt_o, bus.halt_o, bus.busy_o, low(pv), r);
            end
          end
        end
      end
    end
  endtask

  initial begin
    bus.error_i  = '0;
    bus.halted_i = 1'b0;
    test_reset();
    test_single_error();
    test_double_error();
    test_halt_timeout();
    test_retry_chain();
    test_reset_mid_copy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
